// File: rtl/single_macc_pkg.sv
// Shared definitions for the single-MACC filter family: data width, accumulator
// sizing, FSM state encoding and saturation limits.
package single_macc_pkg;

    // Sample and coefficient width, signed Q1.17
    localparam int DATA_W = 18;

    typedef enum logic [1:0] {
        CLR,
        IDLE,
        MAC
    } state_t;

    // Full product plus enough guard bits to sum one phase without overflow
    function automatic int acc_width(input int data_w, input int taps_per_phase);
        return 2 * data_w + $clog2(taps_per_phase);
    endfunction

    // Largest positive value representable in a signed word of width w
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value representable in a signed word of width w
    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/single_macc_unit.sv
// Single multiply-accumulate datapath: registered multiply, accumulate with
// per-phase reload, then round/shift/saturate into an output register.
// Build option: SINGLE_MACC_INTERP_ROUND_EN selects round-half-up instead of
// truncation before saturation; latency is the same either way.
module single_macc_unit
    import single_macc_pkg::*;
#(
    parameter int DataW = DATA_W,
    parameter int AccW  = acc_width(DATA_W, 8)
) (
    input  logic                    i_clk,
    input  logic                    i_srst,
    input  logic signed [DataW-1:0] i_x,
    input  logic signed [DataW-1:0] i_h,
    input  logic                    i_vld,
    input  logic                    i_first,
    input  logic                    i_last,
    output logic signed [DataW-1:0] o_data,
    output logic                    o_valid
);

    localparam logic signed [AccW:0] W_HI = (AccW + 1)'(sat_max(DataW));
    localparam logic signed [AccW:0] W_LO = (AccW + 1)'(sat_min(DataW));
`ifdef SINGLE_MACC_INTERP_ROUND_EN
    localparam logic signed [AccW:0] W_RND = (AccW + 1)'(1) <<< (DataW - 2);
`endif

    logic signed [2*DataW-1:0] r_prod;
    logic                      r_prod_vld;
    logic                      r_prod_first;
    logic                      r_prod_last;
    logic signed [AccW-1:0]    r_acc;
    logic                      r_acc_done;
    logic signed [AccW-1:0]    w_prod_ext;
    logic signed [AccW:0]      w_biased;
    logic signed [AccW:0]      w_shifted;
    logic signed [DataW-1:0]   w_sat;

    assign w_prod_ext = AccW'(r_prod);

    // Multiply stage: one product per cycle, control flags travel alongside
    always_ff @(posedge i_clk) begin
        r_prod <= (2 * DataW)'(i_x) * (2 * DataW)'(i_h);
        if (i_srst) begin
            r_prod_vld   <= 1'b0;
            r_prod_first <= 1'b0;
            r_prod_last  <= 1'b0;
        end else begin
            r_prod_vld   <= i_vld;
            r_prod_first <= i_vld & i_first;
            r_prod_last  <= i_vld & i_last;
        end
    end

    // Accumulate stage: first product of a phase reloads, so phases run back-to-back
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_acc      <= '0;
            r_acc_done <= 1'b0;
        end else begin
            r_acc_done <= r_prod_vld & r_prod_last;
            if (r_prod_vld) begin
                r_acc <= r_prod_first ? w_prod_ext : r_acc + w_prod_ext;
            end
        end
    end

    // Scale Q2.34-plus-guard accumulator back to Q1.17 and clamp
    always_comb begin
`ifdef SINGLE_MACC_INTERP_ROUND_EN
        w_biased = {r_acc[AccW-1], r_acc} + W_RND;
`else
        w_biased = {r_acc[AccW-1], r_acc};
`endif
        w_shifted = w_biased >>> (DataW - 1);
        w_sat     = DataW'(w_shifted);
        if (w_shifted > W_HI) begin
            w_sat = DataW'(W_HI);
        end else if (w_shifted < W_LO) begin
            w_sat = DataW'(W_LO);
        end
    end

    // Output register: updates and pulses only when a phase sum completes
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= r_acc_done;
            if (r_acc_done) begin
                o_data <= w_sat;
            end
        end
    end

endmodule

// File: rtl/single_macc_interpolator.sv
// Polyphase FIR interpolator built around one MAC: each accepted sample yields
// InterpolationK outputs, one per phase, each a TPP-tap dot product.
// Build option: SINGLE_MACC_INTERP_ROUND_EN (rounding in the MAC output stage).
module single_macc_interpolator
    import single_macc_pkg::*;
#(
    parameter int InterpolationK = 2,
    parameter int TapsNum        = 16,
    parameter int DataW          = DATA_W
) (
    input  logic                       Clk_i,
    input  logic                       Rst_i,
    input  logic [$clog2(TapsNum)-1:0] CoeffAddr_i,
    input  logic signed [DataW-1:0]    CoeffData_i,
    input  logic                       CoeffWr_i,
    input  logic signed [DataW-1:0]    Data_i,
    input  logic                       DataNd_i,
    output logic signed [DataW-1:0]    Data_o,
    output logic                       DataValid_o,
    output logic                       Busy_o,
    output logic                       Overrun_o
);

    localparam int TPP      = TapsNum / InterpolationK;
    localparam int PTR_W    = (TPP > 1) ? $clog2(TPP) : 1;
    localparam int PH_W     = (InterpolationK > 1) ? $clog2(InterpolationK) : 1;
    localparam int CA_W     = $clog2(TapsNum);
    localparam int ACC_W    = acc_width(DataW, TPP);
    localparam int CNT_W    = $clog2(TapsNum + 3);
    // Two extra cycles after the last issue cover the multiply and accumulate stages
    localparam logic [CNT_W-1:0] CNT_ISSUE = CNT_W'(TapsNum);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TapsNum + 2);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(TPP - 1);
    localparam logic [CA_W-1:0]  K_C       = CA_W'(InterpolationK);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_clr_cnt;
    logic [PTR_W-1:0]        r_tap;
    logic [PH_W-1:0]         r_phase;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [DataW-1:0] r_dline [TPP];
    logic signed [DataW-1:0] r_coef  [TapsNum];
    logic signed [DataW-1:0] r_x;
    logic signed [DataW-1:0] r_h;
    logic                    r_rd_vld;
    logic                    r_rd_first;
    logic                    r_rd_last;
    logic                    r_overrun;
    logic                    w_accept;
    logic                    w_issue;
    logic [PTR_W:0]          w_rd_sum;
    logic [PTR_W-1:0]        w_rd_addr;
    logic [CA_W-1:0]         w_coef_addr;

    assign w_accept  = (r_state == IDLE) && DataNd_i && !Rst_i;
    assign w_issue   = (r_state == MAC) && (r_cnt < CNT_ISSUE);
    assign Busy_o    = (r_state != IDLE);
    assign Overrun_o = r_overrun;

    // State register
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_state <= CLR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: clear the delay line, wait for a sample, run all phases
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            CLR:     if (r_clr_cnt == PTR_LAST) w_state_next = IDLE;
            IDLE:    if (w_accept)              w_state_next = MAC;
            MAC:     if (r_cnt == CNT_LAST)     w_state_next = IDLE;
            default: w_state_next = CLR;
        endcase
    end

    // Pointer and tap/phase counters
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_wptr    <= '0;
            r_clr_cnt <= '0;
            r_tap     <= '0;
            r_phase   <= '0;
            r_cnt     <= '0;
        end else begin
            unique case (r_state)
                CLR: r_clr_cnt <= (r_clr_cnt == PTR_LAST) ? '0 : r_clr_cnt + 1'b1;
                IDLE: begin
                    if (w_accept) begin
                        r_wptr  <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
                        r_tap   <= '0;
                        r_phase <= '0;
                        r_cnt   <= '0;
                    end
                end
                MAC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_issue) begin
                        if (r_tap == PTR_LAST) begin
                            r_tap   <= '0;
                            r_phase <= r_phase + 1'b1;
                        end else begin
                            r_tap <= r_tap + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tap j of the current burst reads x[n-j]; the newest sample sits just behind r_wptr
    always_comb begin
        w_rd_sum  = {1'b0, r_wptr} + (PTR_W + 1)'(TPP - 1) - {1'b0, r_tap};
        w_rd_addr = PTR_W'(w_rd_sum);
        if (w_rd_sum >= (PTR_W + 1)'(TPP)) begin
            w_rd_addr = PTR_W'(w_rd_sum - (PTR_W + 1)'(TPP));
        end
        w_coef_addr = CA_W'(r_tap) * K_C + CA_W'(r_phase);
    end

    // Delay-line RAM: zero-fill while clearing, otherwise store accepted samples
    always_ff @(posedge Clk_i) begin
        if (r_state == CLR) begin
            r_dline[r_clr_cnt] <= '0;
        end else if (w_accept) begin
            r_dline[r_wptr] <= Data_i;
        end
        r_x <= r_dline[w_rd_addr];
    end

    // Coefficient RAM: writable at any time, never cleared by reset
    always_ff @(posedge Clk_i) begin
        if (CoeffWr_i) begin
            r_coef[CoeffAddr_i] <= CoeffData_i;
        end
        r_h <= r_coef[w_coef_addr];
    end

    // Flags aligned with the registered RAM reads
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_rd_vld   <= 1'b0;
            r_rd_first <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_vld   <= w_issue;
            r_rd_first <= (r_tap == '0);
            r_rd_last  <= (r_tap == PTR_LAST);
        end
    end

    // Flag samples that arrive while the engine cannot take them
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= DataNd_i && (r_state != IDLE);
        end
    end

    single_macc_unit #(
        .DataW (DataW),
        .AccW  (ACC_W)
    ) u_macc (
        .i_clk   (Clk_i),
        .i_srst  (Rst_i),
        .i_x     (r_x),
        .i_h     (r_h),
        .i_vld   (r_rd_vld),
        .i_first (r_rd_first),
        .i_last  (r_rd_last),
        .o_data  (Data_o),
        .o_valid (DataValid_o)
    );

endmodule

// File: tb/tb_single_macc_interpolator.sv
// Self-checking bench for single_macc_interpolator (K=2, 16 taps, 8 per phase).
// Honours SINGLE_MACC_INTERP_ROUND_EN for the expected output scaling.
module tb_single_macc_interpolator;

    localparam int K   = 2;
    localparam int NT  = 16;
    localparam int TPP = NT / K;
    localparam longint NONE = 64'sd1 <<< 40;
`ifdef SINGLE_MACC_INTERP_ROUND_EN
    localparam longint RND = 1;
`else
    localparam longint RND = 0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         caddr;
    logic signed [17:0] cdata;
    logic               cwr;
    logic signed [17:0] din;
    logic               dnd;
    logic signed [17:0] dout;
    logic               dvalid;
    logic               busy;
    logic               ovr;

    int total = 0;
    int bad   = 0;

    longint coef_m [NT];
    longint hist[$];

    always #5 clk = ~clk;

    single_macc_interpolator #(
        .InterpolationK (K),
        .TapsNum        (NT),
        .DataW          (18)
    ) dut (
        .Clk_i       (clk),
        .Rst_i       (rst),
        .CoeffAddr_i (caddr),
        .CoeffData_i (cdata),
        .CoeffWr_i   (cwr),
        .Data_i      (din),
        .DataNd_i    (dnd),
        .Data_o      (dout),
        .DataValid_o (dvalid),
        .Busy_o      (busy),
        .Overrun_o   (ovr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference: y_p = sum_j x[n-j]*h[j*K+p], scaled by 2^-17, clamped to 18 bits
    function automatic longint model_out(input int p);
        longint acc = 0;
        longint y;
        for (int j = 0; j < TPP; j++) acc += hist[j] * coef_m[j*K+p];
        acc += RND * 65536;
        y = acc >>> 17;
        if (y > 131071) y = 131071;
        if (y < -131072) y = -131072;
        return y;
    endfunction

    task automatic clear_model;
        hist.delete();
        for (int j = 0; j < TPP; j++) hist.push_back(0);
    endtask

    task automatic wcoef(input int addr, input longint val);
        caddr = 4'(addr);
        cdata = 18'(val);
        cwr   = 1'b1;
        tick;
        cwr   = 1'b0;
        coef_m[addr] = val;
    endtask

    // Send one sample, watch the burst for 30 cycles, optionally inject a second strobe
    task automatic send(input longint x, input int ovr_at, output longint v0, output longint v1);
        longint e0, e1;
        longint vals[$];
        int tv[$];
        int bfall = -1;
        int novr = 0;
        din = 18'(x);
        dnd = 1'b1;
        tick;
        dnd = 1'b0;
        hist.push_front(x);
        void'(hist.pop_back());
        e0 = model_out(0);
        e1 = model_out(1);
        for (int k = 0; k < 30; k++) begin
            if (dvalid) begin
                vals.push_back(longint'(dout));
                tv.push_back(k);
            end
            if (ovr) novr++;
            if (!busy && bfall < 0) bfall = k;
            if (ovr_at > 0 && k == ovr_at - 1) begin
                din = 18'($urandom);
                dnd = 1'b1;
            end else begin
                dnd = 1'b0;
            end
            tick;
        end
        v0 = (vals.size() > 0) ? vals[0] : NONE;
        v1 = (vals.size() > 1) ? vals[1] : NONE;
        check("valid_count", longint'(vals.size()), 2);
        check("phase0_value", v0, e0);
        check("phase1_value", v1, e1);
        check("phase0_latency", (tv.size() > 0) ? longint'(tv[0]) : -1, 11);
        check("phase1_latency", (tv.size() > 1) ? longint'(tv[1]) : -1, 19);
        check("busy_fall", longint'(bfall), 19);
        check("overrun_pulses", longint'(novr), (ovr_at > 0) ? 1 : 0);
        $display("sample x=%0d -> y0=%0d y1=%0d (model %0d %0d)", x, v0, v1, e0, e1);
    endtask

    task automatic impulse_seq(input string tag);
        longint v0, v1;
        for (int i = 0; i < TPP; i++) begin
            send((i == 0) ? 131071 : 0, 0, v0, v1);
            check({tag, "_p0"}, v0, 2*i + RND);
            check({tag, "_p1"}, v1, 2*i + 1 + RND);
        end
    endtask

    initial begin
        longint v0, v1;
        int n, npre, npost;
        rst = 1'b1; cwr = 1'b0; dnd = 1'b0; caddr = '0; cdata = '0; din = '0;
        for (int i = 0; i < NT; i++) coef_m[i] = 0;
        repeat (3) tick;
        check("rst_data", longint'(dout), 0);
        check("rst_valid", longint'(dvalid), 0);
        check("rst_overrun", longint'(ovr), 0);
        check("rst_busy", longint'(busy), 1);
        rst = 1'b0;
        n = 0;
        while (busy && n < 40) begin tick; n++; end
        check("clr_cycles", longint'(n), 8);
        clear_model();

        // Impulse response: h[i]=i+1 read back one coefficient per output
        for (int i = 0; i < NT; i++) wcoef(i, i + 1);
        impulse_seq("impulse");

        // Second strobe 5 cycles in must be dropped
        send(longint'($urandom_range(0, 131071)), 5, v0, v1);

        // Reset between the two outputs of a burst
        din = 18'(131071);
        dnd = 1'b1;
        tick;
        dnd = 1'b0;
        npre = 0;
        for (int k = 0; k < 14; k++) begin
            if (dvalid) npre++;
            tick;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n = 0;
        npost = 0;
        while (busy && n < 40) begin
            if (dvalid) npost++;
            tick;
            n++;
        end
        repeat (12) begin
            if (dvalid) npost++;
            tick;
        end
        check("rst_mid_pre_pulses", longint'(npre), 1);
        check("rst_mid_clr_cycles", longint'(n), 8);
        check("rst_mid_post_pulses", longint'(npost), 0);
        $display("mid-burst reset: pulses before=%0d after=%0d clr=%0d", npre, npost, n);
        clear_model();
        impulse_seq("impulse_after_rst");

        // Random coefficients and samples against the model
        for (int i = 0; i < NT; i++) wcoef(i, longint'($urandom_range(0, 32768)) - 16384);
        for (int i = 0; i < 20; i++) begin
            logic signed [17:0] r;
            r = 18'($urandom);
            send(longint'(r), 0, v0, v1);
        end

        // Saturation in both directions
        for (int i = 0; i < NT; i++) wcoef(i, 32768);
        for (int i = 0; i < TPP; i++) send(131071, 0, v0, v1);
        check("sat_pos_p0", v0, 131071);
        check("sat_pos_p1", v1, 131071);
        for (int i = 0; i < TPP; i++) send(-131072, 0, v0, v1);
        check("sat_neg_p0", v0, -131072);
        check("sat_neg_p1", v1, -131072);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
